mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 selection path (mux4-style, 2-bit control) between four requesters.
- Produces a one-hot grant and the matching 2-bit select for the shared mux.
- Bounds ownership with a hold limit, so no requester can starve the others.
- Sits between requester control logic and the shared mux4 bank that steers one requester's data onto a common bus.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one owner keeps the grant while other requests are pending. Legal range is 1..15.
- CNT_W, 4: width of the hold counter. Must hold the value MAX_HOLD.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  4  request per requester, level-sensitive. req[i] stays high while requester i wants the bus.
- grant  output  4  one-hot grant, registered. All zero when idle.
- sel  output  2  mux control, registered. Equals the binary index of the granted requester; holds the last owner when idle.
- busy  output  1  registered. Equals |grant.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-grant):
  - grant=0000, sel=00, busy=0.
  - State=IDLE, hold_cnt=0, last=3, so requester 0 has top priority after reset.
- All state updates happen on the rising clock edge. Outputs are registered; there is no combinational path from req to grant.
- Rotating pick, pick(start, mask): first index k in the order start, start+1, ... (mod 4) with mask[k]=1. It reports "none" if mask==0.
- IDLE:
  - If req!=0: next=pick(last+1, req). Go to GRANT; grant=onehot(next), sel=next, hold_cnt=1.
  - Latency is 1 cycle from req sampled high to grant high.
  - If req==0: stay in IDLE; outputs unchanged (grant=0, sel holds its value).
- GRANT, owner o. Release is required when either:
  - req[o]==0, or
  - hold_cnt==MAX_HOLD and (req & ~onehot(o))!=0.
- On release:
  - last=o.
  - If (req & ~onehot(o))!=0: next=pick(o+1, req & ~onehot(o)). Hand off in the same edge with no idle bubble: grant=onehot(next), sel=next, hold_cnt=1.
  - Otherwise: go to IDLE; grant=0000, sel holds o.
- No release:
  - Keep the grant.
  - hold_cnt increments, saturating at MAX_HOLD.
  - A lone requester keeps the grant indefinitely. If a competitor then appears while hold_cnt==MAX_HOLD, handoff occurs at the next edge.
- Invariants:
  - grant is zero-hot or one-hot.
  - When grant!=0, sel equals the index of its set bit.
  - busy==(grant!=0).
  - hold_cnt never exceeds MAX_HOLD.
- A requester that drops and re-raises req in back-to-back cycles is treated as a new request and is subject to rotation.
- MAX_HOLD=1: the grant rotates every cycle whenever two or more requesters are active.

Decomposition:
- Shared package holds:
  - N_REQ=4 and SEL_W=2.
  - State encoding: IDLE=1'b0, GRANT=1'b1.
  - Default MAX_HOLD.
- One natural sub-module, rr_pick: purely combinational rotating priority picker.
  - Inputs: start[1:0], mask[3:0].
  - Outputs: idx[1:0], found.
  - Instantiated twice: for the idle pick and for the handoff pick.
- The top level holds the state register, hold counter, last pointer and output registers.

Test Plan:
- Reset then single request: req=0100 at cycle 0 -> grant=0100, sel=10, busy=1 at cycle 1. Drop req at cycle 5 -> grant=0000, busy=0, sel=10 at cycle 6.
- Round-robin fairness with MAX_HOLD=4: req=1111 held -> owners 0,1,2,3,0,... Each owner holds exactly 4 cycles. Handoffs have no zero-grant cycle.
- Early release with handoff: owner 1 and req=1010. Drop req[1] at cycle k -> grant=1000, sel=11 at cycle k+1, hold_cnt restarts at 1.
- Lone owner past limit: req=0001 held 10 cycles -> grant stays 0001. Raise req[2] -> grant=0100, sel=10 on the next edge.
- Asynchronous reset mid-grant: owner 3, reset_n low between clock edges -> grant=0000, sel=00, busy=0 immediately. After release with req=1111 -> first grant is 0001.
- Rotation skip: last owner 0, req=1001 -> next grant 1000. Requester 0 is granted only after requester 3 releases or expires.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and helpers for the mux4 round-robin arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned N_REQ            = 4;
  localparam int unsigned SEL_W            = 2;
  localparam int unsigned DEFAULT_MAX_HOLD = 4;
  localparam int unsigned DEFAULT_CNT_W    = 4;

  // Arbiter state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Binary index to one-hot requester vector
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/arbiter bus: request vector in, grant/select/busy out.
//   req   : level request per requester
//   grant : one-hot grant
//   sel   : binary select for the shared mux4
//   busy  : any grant active
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             busy;

  // Requester side
  modport master (output req, input grant, input sel, input busy);
  // Arbiter side
  modport slave  (input req, output grant, output sel, output busy);
endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   start : first index considered
//   mask  : candidate vector
//   idx   : first set index in order start, start+1, ... (mod 4)
//   found : mask had at least one bit set
module rr_pick
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [SEL_W-1:0] start,
  input  logic [N_REQ-1:0] mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Scan from start; the first hit wins
  always_comb begin
    idx   = start;
    found = 1'b0;
    cand  = start;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand = SEL_W'(start + SEL_W'(i));
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter with hold limit driving a shared mux4 select.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of mux4_rr_arbiter_if (req in; grant/sel/busy out, registered)
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  mux4_rr_arbiter_if.slave  bus
);

  logic [0:0]       state_q,    state_n;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_n;
  logic [SEL_W-1:0] last_q,     last_n;
  logic [N_REQ-1:0] grant_q,    grant_n;
  logic [SEL_W-1:0] sel_q,      sel_n;
  logic             busy_q,     busy_n;

  logic [N_REQ-1:0] others_c;
  logic [SEL_W-1:0] idle_idx_c, hand_idx_c;
  logic             idle_found_c, hand_found_c;
  logic             at_limit_c, release_c;

  // While granted, sel_q is the current owner
  assign others_c   = bus.req & ~onehot(sel_q);
  assign at_limit_c = (hold_cnt_q == CNT_W'(MAX_HOLD));
  assign release_c  = !bus.req[sel_q] || (at_limit_c && (others_c != '0));

  // Fresh pick out of idle, rotating from the previous owner
  rr_pick u_pick_idle (
    .start (SEL_W'(last_q + SEL_W'(1))),
    .mask  (bus.req),
    .idx   (idle_idx_c),
    .found (idle_found_c)
  );

  // Same-edge handoff pick, excluding the releasing owner
  rr_pick u_pick_hand (
    .start (SEL_W'(sel_q + SEL_W'(1))),
    .mask  (others_c),
    .idx   (hand_idx_c),
    .found (hand_found_c)
  );

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      last_q     <= SEL_W'(N_REQ - 1);
      grant_q    <= '0;
      sel_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      hold_cnt_q <= hold_cnt_n;
      last_q     <= last_n;
      grant_q    <= grant_n;
      sel_q      <= sel_n;
      busy_q     <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    hold_cnt_n = hold_cnt_q;
    last_n     = last_q;
    grant_n    = grant_q;
    sel_n      = sel_q;

    case (state_q)
      ST_IDLE: begin
        if (idle_found_c) begin
          state_n    = ST_GRANT;
          grant_n    = onehot(idle_idx_c);
          sel_n      = idle_idx_c;
          hold_cnt_n = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (release_c) begin
          last_n = sel_q;
          if (hand_found_c) begin
            grant_n    = onehot(hand_idx_c);
            sel_n      = hand_idx_c;
            hold_cnt_n = CNT_W'(1);
          end else begin
            state_n    = ST_IDLE;
            grant_n    = '0;
            hold_cnt_n = '0;
          end
        end else if (!at_limit_c) begin
          hold_cnt_n = CNT_W'(hold_cnt_q + CNT_W'(1));
        end
      end
      default: begin
        state_n    = ST_IDLE;
        grant_n    = '0;
        hold_cnt_n = '0;
      end
    endcase

    busy_n = (grant_n != '0);
  end

  assign bus.grant = grant_q;
  assign bus.sel   = sel_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios plus random
// request traffic, compared every cycle against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic clock;
  logic reset_n;
  int   total;
  int   bad;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: owner index (-1 when idle), hold count, last owner
  int m_owner;
  int m_cnt;
  int m_last;
  int m_sel;

  function automatic int pick(input int start, input logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    logic [3:0] others;
    int p;
    if (!reset_n) begin
      m_owner = -1;
      m_cnt   = 0;
      m_last  = 3;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      p = pick((m_last + 1) % 4, bus.req);
      if (p >= 0) begin
        m_owner = p;
        m_sel   = p;
        m_cnt   = 1;
      end
    end else begin
      others = bus.req;
      others[m_owner] = 1'b0;
      if (!bus.req[m_owner] || (m_cnt == MAX_HOLD && others != 4'b0000)) begin
        m_last = m_owner;
        p = pick((m_owner + 1) % 4, others);
        if (p >= 0) begin
          m_owner = p;
          m_sel   = p;
          m_cnt   = 1;
        end else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end else if (m_cnt < MAX_HOLD) begin
        m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic cmp(input string name, input logic [3:0] g, input logic [1:0] s, input logic b);
    total++;
    if (bus.grant !== g || bus.sel !== s || bus.busy !== b) begin
      bad++;
      $display("FAIL %s at %0t: got grant=%b sel=%0d busy=%b, want grant=%b sel=%0d busy=%b",
               name, $time, bus.grant, bus.sel, bus.busy, g, s, b);
    end
  endtask

  // Advance to the next falling edge and check against the model
  task automatic tick();
    logic [3:0] g;
    @(negedge clock);
    g = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    cmp("model", g, 2'(m_sel), m_owner >= 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    bus.req = 4'b0000;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    bus.req = 4'b0000;
    reset_n = 1'b0;
    #1;
    cmp("reset_state", 4'b0000, 2'd0, 1'b0);
    tick();
    reset_n = 1'b1;

    // Single request, then drop
    do_reset();
    bus.req = 4'b0100;
    tick();
    cmp("single_grant", 4'b0100, 2'd2, 1'b1);
    repeat (4) tick();
    bus.req = 4'b0000;
    tick();
    cmp("single_release", 4'b0000, 2'd2, 1'b0);

    // Fairness: all requesting, each owner holds exactly MAX_HOLD cycles
    do_reset();
    bus.req = 4'b1111;
    for (int c = 0; c < 16; c++) begin
      logic [3:0] g;
      tick();
      g = 4'(1 << (c / MAX_HOLD));
      cmp("rr_fair", g, 2'(c / MAX_HOLD), 1'b1);
    end
    tick();
    cmp("rr_wrap", 4'b0001, 2'd0, 1'b1);

    // Lone owner past the limit, then a competitor appears
    do_reset();
    bus.req = 4'b0001;
    repeat (10) tick();
    cmp("lone_hold", 4'b0001, 2'd0, 1'b1);
    bus.req = 4'b0101;
    tick();
    cmp("lone_handoff", 4'b0100, 2'd2, 1'b1);

    // Early release with handoff
    do_reset();
    bus.req = 4'b1010;
    tick();
    cmp("early_owner", 4'b0010, 2'd1, 1'b1);
    bus.req = 4'b1000;
    tick();
    cmp("early_handoff", 4'b1000, 2'd3, 1'b1);

    // Asynchronous reset mid-grant
    do_reset();
    bus.req = 4'b1000;
    tick();
    cmp("async_owner3", 4'b1000, 2'd3, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    cmp("async_reset", 4'b0000, 2'd0, 1'b0);
    tick();
    bus.req = 4'b1111;
    reset_n = 1'b1;
    tick();
    cmp("async_first", 4'b0001, 2'd0, 1'b1);

    // Rotation skip past the last owner
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0000;
    tick();
    cmp("skip_idle", 4'b0000, 2'd0, 1'b0);
    bus.req = 4'b1001;
    tick();
    cmp("skip_grant3", 4'b1000, 2'd3, 1'b1);
    repeat (4) tick();
    cmp("skip_back0", 4'b0001, 2'd0, 1'b1);

    // Random traffic with occasional asynchronous reset pulses
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) bus.req[b] = ~bus.req[b];
      end
      if ($urandom_range(299) == 0) begin
        #2 reset_n = 1'b0;
        #1 cmp("rand_reset", 4'b0000, 2'd0, 1'b0);
        tick();
        reset_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
